// File: rtl/led_pattern_bank_if.sv
// Configuration and sync bus for led_pattern_bank.
// The sequencer (master) drives every signal and the LED bank (slave) samples them.
interface led_pattern_bank_if #(
    parameter int CHANNELS = 4,
    parameter int PERIOD_W = 16,
    parameter int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);
    logic                cfg_we;
    logic [SEL_W-1:0]    cfg_sel;
    logic [1:0]          cfg_mode;
    logic [PERIOD_W-1:0] cfg_period;
    logic [PERIOD_W-1:0] cfg_duty;
    logic                sync;

    modport master (output cfg_we, cfg_sel, cfg_mode, cfg_period, cfg_duty, sync);
    modport slave  (input  cfg_we, cfg_sel, cfg_mode, cfg_period, cfg_duty, sync);
endinterface

// File: rtl/led_pattern_bank.sv
// Multi-channel LED driver. Each channel runs OFF/ON/BLINK/PWM from its own period and duty,
// and is loaded over a single-cycle write port. sync restarts every channel in phase.
//
//   mode       | meaning
//   MODE_OFF   | led held 0, counter idle
//   MODE_ON    | led held 1, counter idle
//   MODE_BLINK | led toggles on every counter wrap
//   MODE_PWM   | led high while the next count is below duty
module led_pattern_bank #(
    parameter int CHANNELS = 4,
    parameter int PERIOD_W = 16,
    parameter int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    led_pattern_bank_if.slave   cfg,
    output logic [CHANNELS-1:0] led,
    output logic [CHANNELS-1:0] wrap
);
    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_PWM   = 2'd3
    } mode_t;

    mode_t               mode_q   [CHANNELS];
    logic [PERIOD_W-1:0] period_q [CHANNELS];
    logic [PERIOD_W-1:0] duty_q   [CHANNELS];
    logic [PERIOD_W-1:0] cnt_q    [CHANNELS];
    logic [PERIOD_W-1:0] cnt_nxt  [CHANNELS];
    logic [CHANNELS-1:0] hit;
    logic [CHANNELS-1:0] last;

    function automatic logic init_led(input mode_t m, input logic [PERIOD_W-1:0] d);
        case (m)
            MODE_ON:  return 1'b1;
            MODE_PWM: return d != '0;
            default:  return 1'b0;
        endcase
    endfunction

    // An out-of-range select matches no channel, so invalid writes vanish here.
    always_comb begin
        hit  = '0;
        last = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            hit[i]     = cfg.cfg_we && (cfg.cfg_sel == SEL_W'(i));
            last[i]    = (cnt_q[i] == period_q[i] - PERIOD_W'(1));
            cnt_nxt[i] = last[i] ? '0 : cnt_q[i] + PERIOD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                mode_q[i]   <= MODE_OFF;
                period_q[i] <= '0;
                duty_q[i]   <= '0;
                cnt_q[i]    <= '0;
                led[i]      <= 1'b0;
                wrap[i]     <= 1'b0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (hit[i] || cfg.sync) begin
                    cnt_q[i] <= '0;
                    wrap[i]  <= 1'b0;
                    if (hit[i]) begin
                        mode_q[i]   <= mode_t'(cfg.cfg_mode);
                        period_q[i] <= cfg.cfg_period;
                        duty_q[i]   <= cfg.cfg_duty;
                        led[i]      <= init_led(mode_t'(cfg.cfg_mode), cfg.cfg_duty);
                    end else begin
                        led[i]      <= init_led(mode_q[i], duty_q[i]);
                    end
                end else begin
                    case (mode_q[i])
                        MODE_OFF: begin
                            cnt_q[i] <= '0;
                            wrap[i]  <= 1'b0;
                            led[i]   <= 1'b0;
                        end
                        MODE_ON: begin
                            cnt_q[i] <= '0;
                            wrap[i]  <= 1'b0;
                            led[i]   <= 1'b1;
                        end
                        default: begin
                            // period 0 pauses the channel: everything holds.
                            if (period_q[i] != '0) begin
                                cnt_q[i] <= cnt_nxt[i];
                                wrap[i]  <= last[i];
                                if (mode_q[i] == MODE_BLINK) begin
                                    if (last[i]) led[i] <= ~led[i];
                                end else begin
                                    led[i] <= (cnt_nxt[i] < duty_q[i]);
                                end
                            end
                        end
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_led_pattern_bank.sv
// Directed bench for led_pattern_bank: reset, blink sweep, PWM patterns, sync, collisions,
// invalid select, pause and mid-period reset. Built with 5 channels so select 5 is out of range.
module tb_led_pattern_bank;
    localparam int CH  = 5;
    localparam int PW  = 16;
    localparam int SW  = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [CH-1:0] led;
    logic [CH-1:0] wrap;
    int            checks   = 0;
    int            failures = 0;

    led_pattern_bank_if #(.CHANNELS(CH), .PERIOD_W(PW)) bus ();

    led_pattern_bank #(.CHANNELS(CH), .PERIOD_W(PW)) dut (
        .clk   (clk),
        .reset (reset),
        .cfg   (bus),
        .led   (led),
        .wrap  (wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int sel, input int mode, input int per, input int duty);
        bus.cfg_sel    = SW'(sel);
        bus.cfg_mode   = 2'(mode);
        bus.cfg_period = PW'(per);
        bus.cfg_duty   = PW'(duty);
        bus.cfg_we     = 1'b1;
        step();
        bus.cfg_we     = 1'b0;
    endtask

    task automatic blink_count(input int ch, output int tog, output int wraps, output int first);
        logic prev;
        tog = 0; wraps = 0; first = 0;
        for (int k = 1; k <= 30; k++) begin
            prev = led[ch];
            step();
            if (led[ch] != prev) begin
                tog++;
                if (first == 0) first = k;
            end
            if (wrap[ch]) wraps++;
        end
    endtask

    task automatic pwm_run(input int duty, input string tag);
        wr(1, 3, 10, duty);
        for (int k = 0; k < 30; k++) begin
            if (k > 0) step();
            chk({tag, "_led"},  32'(led[1]),  32'((duty >= 10) ? 1 : ((k % 10) < duty)));
            chk({tag, "_wrap"}, 32'(wrap[1]), 32'((k > 0) && (k % 10 == 0)));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int tg, wc, fst;
        bus.cfg_we = 1'b0; bus.cfg_sel = '0; bus.cfg_mode = '0;
        bus.cfg_period = '0; bus.cfg_duty = '0; bus.sync = 1'b0;

        // reset wins over a concurrent write and sync
        reset = 1'b1;
        bus.cfg_we = 1'b1; bus.cfg_sel = 0; bus.cfg_mode = 2'd1; bus.cfg_period = 16'd5;
        bus.sync = 1'b1;
        step(); step();
        chk("reset_led",  32'(led),  0);
        chk("reset_wrap", 32'(wrap), 0);
        reset = 1'b0; bus.cfg_we = 1'b0; bus.sync = 1'b0;
        step();
        chk("reset_noload_led", 32'(led), 0);

        wr(0, 2, 3, 0);
        chk("blink3_init", 32'(led[0]), 0);
        blink_count(0, tg, wc, fst);
        chk("blink3_toggles", tg, 10);
        chk("blink3_wraps",   wc, 10);
        chk("blink3_first",   fst, 3);

        for (int p = 1; p <= 141; p++) begin
            wr(0, 2, p, 0);
            blink_count(0, tg, wc, fst);
            chk($sformatf("sweep_tog_p%0d", p),  tg, 30 / p);
            chk($sformatf("sweep_wrap_p%0d", p), wc, 30 / p);
        end

        pwm_run(3,  "pwm_d3");
        pwm_run(0,  "pwm_d0");
        pwm_run(12, "pwm_d12");

        // two blinkers out of phase, then aligned by sync
        wr(0, 2, 4, 0);
        step();
        wr(2, 2, 4, 0);
        bus.sync = 1'b1;
        step();
        bus.sync = 1'b0;
        for (int k = 0; k <= 16; k++) begin
            if (k > 0) step();
            chk($sformatf("sync_ch0_k%0d", k), 32'(led[0]), 32'((k / 4) % 2));
            chk($sformatf("sync_ch2_k%0d", k), 32'(led[2]), 32'((k / 4) % 2));
        end

        // write ch3 ON coincident with sync
        bus.cfg_sel = 3'd3; bus.cfg_mode = 2'd1; bus.cfg_period = 16'd0; bus.cfg_duty = 16'd0;
        bus.cfg_we = 1'b1; bus.sync = 1'b1;
        step();
        bus.cfg_we = 1'b0; bus.sync = 1'b0;
        chk("coll_led",  32'(led),  32'b01010);
        chk("coll_wrap", 32'(wrap), 0);
        step(); step(); step();
        chk("coll_k3", 32'(led), 32'b01010);
        step();
        chk("coll_k4", 32'(led), 32'b01111);
        wr(5, 1, 7, 7);
        chk("invalid_k5", 32'(led), 32'b01111);
        wr(7, 2, 1, 0);
        chk("invalid7_k6", 32'(led), 32'b01111);
        step(); step();
        chk("invalid_k8", 32'(led), 32'b01010);

        wr(4, 2, 0, 0);
        for (int k = 0; k < 10; k++) begin
            chk("pause_led",  32'(led[4]),  0);
            chk("pause_wrap", 32'(wrap[4]), 0);
            step();
        end

        wr(1, 3, 10, 3);
        step();
        chk("midrst_pre", 32'(led[1]), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst_led",  32'(led),  0);
        chk("midrst_wrap", 32'(wrap), 0);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("midrst_off", 32'({wrap, led}), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
